tt_um_willow240_uart_tx: RTL

Byte-wide asynchronous serial transmitter for the Willow240 TinyTapeout tile. Other end of the tile's parallel byte-input path: a byte on `ui_in` is accepted with a valid/ready handshake on the bidirectional pins and shifted out on `uo_out[0]` as a UART frame. Frame format: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits. Sits at tile top level and drives all output pins.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 36 +++
 rtl/tt_um_willow240_uart_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the Willow240 UART transmitter.
package uart_tx_pkg;

    localparam int unsigned BAUD_W = 16;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic [BAUD_W-1:0] count,
    output logic              bit_end
);

    localparam logic [BAUD_W-1:0] LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [BAUD_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || count_q == LAST) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign bit_end = (count_q == LAST);

endmodule

// File: rtl/tt_um_willow240_uart_tx.sv
// UART transmitter tile top: valid/ready byte intake on the pins, framed serial out on uo_out[0].
module tt_um_willow240_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    localparam logic [BAUD_W-1:0] PRE_END = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic              ODD     = (PARITY == PAR_ODD);
    localparam logic              HAS_PAR = (PARITY != PAR_NONE);

    tx_state_e         state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        idx_q, idx_d;
    logic              stop_q, stop_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              bit_end;
    logic              last_stop;
    logic [BAUD_W-1:0] count;
    logic              unused;

    assign unused = ^uio_in[7:1];

    assign accept    = (state_q == StIdle) && uio_in[0] && ena;
    assign last_stop = (STOP_BITS == 2) ? stop_q : 1'b1;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .count  (count),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    shift_d = ui_in;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    par_d   = (^ui_in) ^ ODD;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = HAS_PAR ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    if (last_stop) state_d = StIdle;
                    else stop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from next-state so tx falls on the accepting edge.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        done_d = (state_q == StStop) && last_stop && (count == PRE_END);
        unique case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uo_out  = {5'b0, done_q, busy_q, tx_q};
    assign uio_out = {6'b0, ~busy_q, 1'b0};
    assign uio_oe  = 8'h02;

endmodule
